// File: rtl/phys_accel_pkg.sv
// rtl/phys_accel_pkg.sv - shared types and constants for the physics accelerator blocks
package phys_accel_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COUNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/conv_monitor_if.sv
// rtl/conv_monitor_if.sv - cell stream and status bundle of the convergence monitor
interface conv_monitor_if
  import phys_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic                     cell_valid;
  logic signed [DATA_W-1:0] cell_new;
  logic signed [DATA_W-1:0] cell_old;
  logic                     sweep_last;
  logic                     conv_flag;
  logic                     timeout;
  logic [COUNT_W-1:0]       sweep_count;
  logic [COUNT_W-1:0]       stable_count;

  modport master (
    output cell_valid, cell_new, cell_old, sweep_last,
    input  conv_flag, timeout, sweep_count, stable_count
  );

  modport slave (
    input  cell_valid, cell_new, cell_old, sweep_last,
    output conv_flag, timeout, sweep_count, stable_count
  );
endinterface

// File: rtl/abs_diff_cmp.sv
// rtl/abs_diff_cmp.sv - |a-b| <= TOL test, evaluated one bit wider so it never overflows
module abs_diff_cmp
  import phys_accel_pkg::*;
#(
  parameter int          DATA_W = DATA_W_DEF,
  parameter int unsigned TOL    = 2
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     within_tol
);
  logic signed [DATA_W:0] diff;
  logic        [DATA_W:0] mag;

  always_comb begin
    diff       = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    mag        = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    within_tol = (mag <= (DATA_W+1)'(TOL));
  end
endmodule

// File: rtl/conv_monitor.sv
// rtl/conv_monitor.sv - counts stable sweeps of an iterative solver and raises a sticky halt
// on convergence or on the sweep limit.
module conv_monitor
  import phys_accel_pkg::*;
#(
  parameter int          DATA_W        = DATA_W_DEF,
  parameter int unsigned TOL           = 2,
  parameter int          STABLE_SWEEPS = 3,
  parameter int          MAX_SWEEPS    = 255
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     cell_valid,
  input  logic signed [DATA_W-1:0] cell_new,
  input  logic signed [DATA_W-1:0] cell_old,
  input  logic                     sweep_last,
  output logic                     CONV_FLAG,
  output logic                     TIMEOUT,
  output logic [COUNT_W-1:0]       sweep_count,
  output logic [COUNT_W-1:0]       stable_count
);
  state_e             state_q, state_d;
  logic               conv_q, conv_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] sweep_count_q, sweep_count_d;
  logic [COUNT_W-1:0] stable_count_q, stable_count_d;
  logic               sweep_ok_q, sweep_ok_d;
  logic               stable_i;

  abs_diff_cmp #(
    .DATA_W (DATA_W),
    .TOL    (TOL)
  ) u_cmp (
    .a          (cell_new),
    .b          (cell_old),
    .within_tol (stable_i)
  );

  always_comb begin
    state_d        = state_q;
    conv_d         = conv_q;
    timeout_d      = timeout_q;
    sweep_count_d  = sweep_count_q;
    stable_count_d = stable_count_q;
    sweep_ok_d     = sweep_ok_q;
    case (state_q)
      IDLE, SWEEP: begin
        if (cell_valid) begin
          state_d    = SWEEP;
          sweep_ok_d = sweep_ok_q & stable_i;
          if (sweep_last) begin
            sweep_count_d  = sweep_count_q + COUNT_W'(1);
            stable_count_d = (sweep_ok_q & stable_i) ? stable_count_q + COUNT_W'(1) : '0;
            sweep_ok_d     = 1'b1;
            // Convergence is tested first so it wins over the limit in the same sweep.
            if (stable_count_d == COUNT_W'(STABLE_SWEEPS)) begin
              state_d   = DONE;
              conv_d    = 1'b1;
              timeout_d = 1'b0;
            end else if (sweep_count_d == COUNT_W'(MAX_SWEEPS)) begin
              state_d   = DONE;
              conv_d    = 1'b1;
              timeout_d = 1'b1;
            end
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      conv_q         <= 1'b0;
      timeout_q      <= 1'b0;
      sweep_count_q  <= '0;
      stable_count_q <= '0;
      sweep_ok_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      conv_q         <= conv_d;
      timeout_q      <= timeout_d;
      sweep_count_q  <= sweep_count_d;
      stable_count_q <= stable_count_d;
      sweep_ok_q     <= sweep_ok_d;
    end
  end

  assign CONV_FLAG    = conv_q;
  assign TIMEOUT      = timeout_q;
  assign sweep_count  = sweep_count_q;
  assign stable_count = stable_count_q;
endmodule

// File: tb/tb_conv_monitor.sv
// tb/tb_conv_monitor.sv - scoreboard bench for conv_monitor across three parameter sets
module tb_conv_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] tb_new, tb_old;
  logic               tb_valid, tb_last, tb_obs;
  logic [2:0]         rst;
  int                 sel;

  typedef struct {
    int         k;
    logic       conv;
    logic       to;
    logic [7:0] sc;
    logic [7:0] stc;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  conv_monitor_if #(.DATA_W(16)) ifa ();
  conv_monitor_if #(.DATA_W(16)) ifb ();
  conv_monitor_if #(.DATA_W(16)) ifc ();

  assign ifa.cell_valid = tb_valid && (sel == 0);
  assign ifb.cell_valid = tb_valid && (sel == 1);
  assign ifc.cell_valid = tb_valid && (sel == 2);
  assign ifa.cell_new = tb_new;  assign ifa.cell_old = tb_old;  assign ifa.sweep_last = tb_last;
  assign ifb.cell_new = tb_new;  assign ifb.cell_old = tb_old;  assign ifb.sweep_last = tb_last;
  assign ifc.cell_new = tb_new;  assign ifc.cell_old = tb_old;  assign ifc.sweep_last = tb_last;

  conv_monitor dut_a (
    .Clk(clk), .Reset(rst[0]), .cell_valid(ifa.cell_valid), .cell_new(ifa.cell_new),
    .cell_old(ifa.cell_old), .sweep_last(ifa.sweep_last), .CONV_FLAG(ifa.conv_flag),
    .TIMEOUT(ifa.timeout), .sweep_count(ifa.sweep_count), .stable_count(ifa.stable_count)
  );

  conv_monitor #(.MAX_SWEEPS(5)) dut_b (
    .Clk(clk), .Reset(rst[1]), .cell_valid(ifb.cell_valid), .cell_new(ifb.cell_new),
    .cell_old(ifb.cell_old), .sweep_last(ifb.sweep_last), .CONV_FLAG(ifb.conv_flag),
    .TIMEOUT(ifb.timeout), .sweep_count(ifb.sweep_count), .stable_count(ifb.stable_count)
  );

  conv_monitor #(.MAX_SWEEPS(3), .STABLE_SWEEPS(3)) dut_c (
    .Clk(clk), .Reset(rst[2]), .cell_valid(ifc.cell_valid), .cell_new(ifc.cell_new),
    .cell_old(ifc.cell_old), .sweep_last(ifc.sweep_last), .CONV_FLAG(ifc.conv_flag),
    .TIMEOUT(ifc.timeout), .sweep_count(ifc.sweep_count), .stable_count(ifc.stable_count)
  );

  // Monitor: any cycle the stimulus marked as observed has one queued expectation.
  initial begin
    exp_t       e;
    logic       ac, at;
    logic [7:0] asc, astc;
    forever begin
      @(posedge clk);
      if (tb_obs) begin
        #1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: output observed with no expectation queued");
        end else begin
          e = sbq.pop_front();
          case (e.k)
            0:       begin ac = ifa.conv_flag; at = ifa.timeout; asc = ifa.sweep_count; astc = ifa.stable_count; end
            1:       begin ac = ifb.conv_flag; at = ifb.timeout; asc = ifb.sweep_count; astc = ifb.stable_count; end
            default: begin ac = ifc.conv_flag; at = ifc.timeout; asc = ifc.sweep_count; astc = ifc.stable_count; end
          endcase
          checks++;
          if (ac !== e.conv || at !== e.to || asc !== e.sc || astc !== e.stc) begin
            errors++;
            $display("FAIL %s dut%0d got conv=%0b to=%0b sc=%0d stc=%0d want conv=%0b to=%0b sc=%0d stc=%0d",
                     e.name, e.k, ac, at, asc, astc, e.conv, e.to, e.sc, e.stc);
          end
        end
      end
    end
  end

  task automatic drive(input int k, input logic v, input logic signed [15:0] n, input logic signed [15:0] o,
                       input logic last, input logic r, input logic ec, input logic et,
                       input int esc, input int estc, input string nm);
    exp_t e;
    @(negedge clk);
    sel      = k;
    tb_valid = v;
    tb_new   = n;
    tb_old   = o;
    tb_last  = last;
    rst      = '0;
    rst[k]   = r;
    tb_obs   = 1'b1;
    e.k = k; e.conv = ec; e.to = et; e.sc = 8'(esc); e.stc = 8'(estc); e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic smp(input int k, input logic signed [15:0] n, input logic signed [15:0] o, input logic last,
                     input logic ec, input logic et, input int esc, input int estc, input string nm);
    drive(k, 1'b1, n, o, last, 1'b0, ec, et, esc, estc, nm);
  endtask

  task automatic rst_chk(input int k, input logic with_sample);
    drive(k, with_sample, 16'sd11, 16'sd99, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "reset");
  endtask

  task automatic quiet();
    @(negedge clk);
    tb_valid = 1'b0;
    tb_last  = 1'b0;
    tb_obs   = 1'b0;
    rst      = '0;
  endtask

  initial begin
    int                 stc_after [6];
    logic signed [15:0] n, o;
    logic               last;
    int                 esc, estc;

    stc_after = '{1, 2, 0, 1, 2, 3};
    tb_valid = 1'b0; tb_last = 1'b0; tb_obs = 1'b0; tb_new = '0; tb_old = '0; sel = 0;
    rst = 3'b111;
    repeat (2) @(negedge clk);

    rst_chk(0, 1'b0);
    rst_chk(1, 1'b0);
    rst_chk(2, 1'b0);

    // Three 4-cell stable sweeps converge; DONE then ignores everything.
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 4; c++) begin
        o    = 16'(37 * s - 20 * c);
        last = (c == 3);
        esc  = last ? s + 1 : s;
        smp(0, o, o, last, (s == 2) && last, 1'b0, esc, esc, "conv3");
      end
    smp(0, 16'sd500, -16'sd500, 1'b1, 1'b1, 1'b0, 3, 3, "done_sticky");
    drive(0, 1'b0, 16'sd1, 16'sd1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3, "done_novalid");

    // One +3 cell breaks the run; +/-2 diffs still count as stable.
    rst_chk(0, 1'b0);
    for (int s = 0; s < 6; s++)
      for (int c = 0; c < 4; c++) begin
        o = 16'(100 * s + 10 * c - 50);
        n = o;
        if (s == 0 && c == 0) n = o + 16'sd2;
        if (s == 0 && c == 2) n = o - 16'sd2;
        if (s == 2 && c == 1) n = o + 16'sd3;
        last = (c == 3);
        esc  = last ? s + 1 : s;
        estc = last ? stc_after[s] : (s == 0 ? 0 : stc_after[s - 1]);
        smp(0, n, o, last, (s == 5) && last, 1'b0, esc, estc, "restart_run");
      end

    // Single-cell sweeps at the arithmetic extremes, with idle cycles in between.
    rst_chk(0, 1'b0);
    smp(0, 16'sh8000, 16'sh7FFF, 1'b1, 1'b0, 1'b0, 1, 0, "min_minus_max");
    drive(0, 1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "last_no_valid");
    smp(0, 16'sh7FFF, 16'sh8000, 1'b1, 1'b0, 1'b0, 2, 0, "max_minus_min");
    smp(0, 16'sd1, -16'sd1, 1'b1, 1'b0, 1'b0, 3, 1, "diff_plus2");
    smp(0, -16'sd1, 16'sd1, 1'b1, 1'b0, 1'b0, 4, 2, "diff_minus2");
    smp(0, 16'sd0, -16'sd3, 1'b1, 1'b0, 1'b0, 5, 0, "diff_plus3");
    smp(0, 16'sh8000, 16'sh8000, 1'b1, 1'b0, 1'b0, 6, 1, "min_eq_min");
    smp(0, 16'sd0, 16'sd3, 1'b1, 1'b0, 1'b0, 7, 0, "diff_minus3");

    // Reset mid-sweep 2 with a sample in the same cycle; next sweep is sweep 1.
    rst_chk(0, 1'b0);
    for (int c = 0; c < 4; c++)
      smp(0, 16'sd9, 16'sd9, c == 3, 1'b0, 1'b0, (c == 3) ? 1 : 0, (c == 3) ? 1 : 0, "pre_reset");
    smp(0, 16'sd4, 16'sd4, 1'b0, 1'b0, 1'b0, 1, 1, "mid_sweep2");
    rst_chk(0, 1'b1);
    for (int c = 0; c < 4; c++)
      smp(0, 16'sd2, 16'sd3, c == 3, 1'b0, 1'b0, (c == 3) ? 1 : 0, (c == 3) ? 1 : 0, "post_reset");

    // Sweep limit 5, every sweep unstable.
    for (int s = 0; s < 5; s++) begin
      smp(1, 16'sd50, 16'sd0, 1'b0, 1'b0, 1'b0, s, 0, "to_unstable");
      smp(1, 16'sd7, 16'sd7, 1'b1, s == 4, s == 4, s + 1, 0, "to_last");
    end
    for (int i = 0; i < 3; i++)
      smp(1, 16'sd1, 16'sd1, 1'b1, 1'b1, 1'b1, 5, 0, "to_sticky");

    // Convergence and limit on the same sweep: convergence wins.
    for (int s = 0; s < 3; s++) begin
      smp(2, -16'sd8, -16'sd7, 1'b0, 1'b0, 1'b0, s, s, "tie_first");
      smp(2, 16'sd8, 16'sd6, 1'b1, s == 2, 1'b0, s + 1, s + 1, "tie_last");
    end

    quiet();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_monitor.md
CONV_MONITOR -- requirements
Module: conv_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter TOL, default 2: maximum per-cell |new-old| counted as stable; unsigned, 0..2^(DATA_W)-1.
REQ-003 SHALL have parameter STABLE_SWEEPS, default 3: consecutive stable sweeps required for convergence; range 1..255.
REQ-004 SHALL have parameter MAX_SWEEPS, default 255: sweep limit before timeout; range 1..255.
REQ-005 SHALL have port Clk, input, 1: single clock, rising edge; reset is synchronous and active-high.
REQ-006 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cell_valid, input, 1: cell_new/cell_old pair valid this cycle.
REQ-008 SHALL have port cell_new, input, DATA_W: updated cell value.
REQ-009 SHALL have port cell_old, input, DATA_W: previous-iteration cell value.
REQ-010 SHALL have port sweep_last, input, 1: qualifies the final cell of a sweep; meaningful only with cell_valid.
REQ-011 SHALL have port CONV_FLAG, output, 1: registered; halts downstream cell shifting when 1.
REQ-012 SHALL have port TIMEOUT, output, 1: registered; the halt was caused by MAX_SWEEPS, not convergence.
REQ-013 SHALL have port sweep_count, output, 8: registered count of completed sweeps.
REQ-014 SHALL have port stable_count, output, 8: registered count of consecutive stable sweeps.

Function
REQ-015 SHALL implement the states IDLE, SWEEP and DONE.
REQ-016 IDLE -> SWEEP on the first cell_valid; that sample SHALL be evaluated in the same cycle.
REQ-017 Per sample: diff = cell_new - cell_old at DATA_W+1 bits, signed; |diff| at DATA_W+1 bits; stable_i = (|diff| <= TOL); no overflow is possible.
REQ-018 SHALL keep a sweep_ok register, set to 1 at sweep start and ANDed with stable_i on every valid sample.
REQ-019 On cell_valid && sweep_last: sweep_count += 1; stable_count = (sweep_ok && stable_i) ? stable_count+1 : 0; sweep_ok := 1.
REQ-020 If the updated stable_count == STABLE_SWEEPS, the FSM SHALL go to DONE with CONV_FLAG=1 and TIMEOUT=0 in the next cycle (latency 1 cycle after the last sample).
REQ-021 Otherwise, if the updated sweep_count == MAX_SWEEPS, the FSM SHALL go to DONE with CONV_FLAG=1 and TIMEOUT=1.
REQ-022 Convergence and limit in the same sweep: convergence SHALL win (TIMEOUT=0).
REQ-023 sweep_last without cell_valid SHALL be ignored.
REQ-024 Cycles with cell_valid=0 SHALL leave all state unchanged.
REQ-025 DONE SHALL be sticky: all inputs ignored, outputs held, until Reset.
REQ-026 A single-cell sweep (every sample carries sweep_last) SHALL be legal.

Reset
REQ-027 Reset=1 at a clock edge SHALL force IDLE, CONV_FLAG=0, TIMEOUT=0, sweep_count=0, stable_count=0 and sweep_ok=1.
REQ-028 A sample presented in the same cycle as Reset SHALL be discarded; reset mid-sweep SHALL abandon the partial sweep.
REQ-029 The first sample after Reset deasserts SHALL be evaluated normally.

Structure
REQ-030 The shared package phys_accel_pkg SHALL hold:
- the state enum (IDLE, SWEEP, DONE);
- the DATA_W default;
- the COUNT_W=8 constant.
REQ-031 SHALL contain one combinational sub-module, abs_diff_cmp (inputs a, b; parameter TOL; output within_tol).
REQ-032 All outputs SHALL be driven directly from flops.

Verification
REQ-033 Default parameters; 4-cell sweeps with new==old for 3 sweeps -> CONV_FLAG=1 one cycle after the 3rd sweep_last; sweep_count=3, stable_count=3.
REQ-034 Stable, stable, then one cell with diff=+3 (TOL=2), then stable x3 -> stable_count goes 1,2,0,1,2,3; CONV_FLAG rises after sweep 6.
REQ-035 Boundary samples: new=-32768/old=32767 and new=32767/old=-32768 -> both unstable; diff exactly +/-2 -> stable.
REQ-036 MAX_SWEEPS=5 with every sweep unstable -> after sweep 5: CONV_FLAG=1, TIMEOUT=1, sweep_count=5; later samples ignored.
REQ-037 MAX_SWEEPS=3, STABLE_SWEEPS=3, all sweeps stable -> CONV_FLAG=1, TIMEOUT=0.
REQ-038 Reset asserted mid-sweep 2 with a valid sample in the same cycle -> all counters 0, state IDLE; the next sweep counts as sweep 1.
